tgate_bus_arbiter: RTL and testbench

Round-robin arbiter that owns the enable lines of N `transmission` gates sharing one analog/digital bus net. Only one gate is ever enabled at a time, and a guaranteed all-off dead interval separates any two grants (break-before-make), so two drivers never contend on the shared node. It sits between the requesting blocks and the transmission-gate array, driving each gate's `en` directly.

---
 rtl/tgate_pkg.sv | 13 +
 rtl/tgate_bus_arbiter_if.sv | 16 +
 rtl/rr_pick.sv | 26 ++
 rtl/tgate_bus_arbiter.sv | 117 +++++++++++
 tb/tb_tgate_bus_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/tgate_pkg.sv
// Shared types and constants for the transmission-gate bus arbiter.
package tgate_pkg;

  localparam int unsigned TG_MAX_N  = 16;
  localparam int unsigned TG_DEAD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DEAD
  } tg_state_e;

endpackage

// File: rtl/tgate_bus_arbiter_if.sv
// Request/enable bundle between requesters, the arbiter and the gate array.
interface tgate_bus_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  en;
  logic [IW-1:0] gnt_id;
  logic          gnt_valid;
  logic          bus_idle;

  modport slave  (input  req, output en, gnt_id, gnt_valid, bus_idle);
  modport master (output req, input  en, gnt_id, gnt_valid, bus_idle);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] pick
);

  logic [IW:0] sum;

  // Scan from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    any  = |req;
    pick = '0;
    sum  = '0;
    for (int i = int'(N); i >= 1; i--) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (req[sum[IW-1:0]]) pick = sum[IW-1:0];
    end
  end

endmodule

// File: rtl/tgate_bus_arbiter.sv
// Break-before-make round-robin owner of N transmission-gate enables on one bus net.
module tgate_bus_arbiter
  import tgate_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned DEAD     = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tgate_bus_arbiter_if.slave  bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  tg_state_e              state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [TG_DEAD_W-1:0]   dead_q, dead_d;
  logic [N-1:0]           en_q, en_d;
  logic [IW-1:0]          id_q, id_d;
  logic                   gv_q, gv_d;
  logic                   idle_q, idle_d;

  logic                   pick_any;
  logic [IW-1:0]          pick_idx;
  logic                   others_c;
  logic                   grant_end_c;
  logic                   dead_done_c;
  logic                   start_c;

  rr_pick #(.N(N)) u_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .any  (pick_any),
    .pick (pick_idx)
  );

  assign others_c    = |(bus.req & ~(N'(1) << ptr_q));
  assign grant_end_c = !bus.req[ptr_q] ||
                       ((MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD)) && others_c);
  assign dead_done_c = (dead_q == TG_DEAD_W'(DEAD));
  assign start_c     = pick_any &&
                       ((state_q == ST_IDLE) || ((state_q == ST_DEAD) && dead_done_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(N - 1);
      hold_q  <= '0;
      dead_q  <= '0;
      en_q    <= '0;
      id_q    <= '0;
      gv_q    <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      en_q    <= en_d;
      id_q    <= id_d;
      gv_q    <= gv_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_GRANT;
      ST_GRANT: if (grant_end_c) state_d = ST_DEAD;
      ST_DEAD:  if (dead_done_c) state_d = pick_any ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, pointer and registered outputs follow the next state.
  always_comb begin
    ptr_d  = ptr_q;
    hold_d = hold_q;
    dead_d = dead_q;
    en_d   = en_q;
    id_d   = id_q;
    gv_d   = (state_d == ST_GRANT);
    idle_d = (state_d == ST_IDLE);
    if (start_c) begin
      en_d   = N'(1) << pick_idx;
      id_d   = pick_idx;
      ptr_d  = pick_idx;
      hold_d = HW'(1);
    end else begin
      unique case (state_q)
        ST_GRANT: begin
          if (grant_end_c) begin
            en_d   = '0;
            dead_d = TG_DEAD_W'(1);
          end else if ((MAX_HOLD != 0) && (hold_q != HW'(MAX_HOLD))) begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_DEAD: begin
          en_d = '0;
          if (!dead_done_c) dead_d = dead_q + TG_DEAD_W'(1);
        end
        default: en_d = '0;
      endcase
    end
  end

  assign bus.en        = en_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = gv_q;
  assign bus.bus_idle  = idle_q;

endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// Directed bench: three arbiter configurations exercised with hand-computed enables.
module tb_tgate_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tgate_bus_arbiter_if #(.N(4)) ifa ();
  tgate_bus_arbiter_if #(.N(4)) ifb ();
  tgate_bus_arbiter_if #(.N(4)) ifc ();

  tgate_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  tgate_bus_arbiter #(.N(4), .DEAD(3), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  tgate_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifa.req = '0;
    ifb.req = '0;
    ifc.req = '0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Enables must never be multi-hot on any instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onehot_a", 32'($onehot0(ifa.en)), 32'd1);
      chk("onehot_b", 32'($onehot0(ifb.en)), 32'd1);
      chk("onehot_c", 32'($onehot0(ifc.en)), 32'd1);
    end
  end

  logic [3:0] rot_seq [13];

  initial begin
    rot_seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    ifa.req = '0;
    ifb.req = '0;
    ifc.req = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_en",    32'(ifa.en), 32'h0);
    chk("rst_valid", 32'(ifa.gnt_valid), 32'h0);
    chk("rst_id",    32'(ifa.gnt_id), 32'h0);
    chk("rst_idle",  32'(ifa.bus_idle), 32'h1);
    chk("rst_idle_c", 32'(ifc.bus_idle), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request and release
    ifa.req = 4'b0001;
    tick();
    chk("single_en",    32'(ifa.en), 32'h1);
    chk("single_valid", 32'(ifa.gnt_valid), 32'h1);
    chk("single_id",    32'(ifa.gnt_id), 32'h0);
    chk("single_busy",  32'(ifa.bus_idle), 32'h0);
    repeat (3) begin
      tick();
      chk("single_hold", 32'(ifa.en), 32'h1);
    end
    ifa.req = 4'b0000;
    tick();
    chk("release_en",    32'(ifa.en), 32'h0);
    chk("release_valid", 32'(ifa.gnt_valid), 32'h0);
    chk("release_dead",  32'(ifa.bus_idle), 32'h0);
    tick();
    chk("release_idle", 32'(ifa.bus_idle), 32'h1);

    // Round-robin rotation with MAX_HOLD=2, DEAD=1
    do_reset();
    ifa.req = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk($sformatf("rot_en_%0d", i), 32'(ifa.en), 32'(rot_seq[i]));
    end

    // Dead interval DEAD=3
    do_reset();
    ifb.req = 4'b0101;
    tick();
    chk("dead_own0", 32'(ifb.en), 32'h1);
    tick();
    chk("dead_own0_hold", 32'(ifb.en), 32'h1);
    ifb.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("dead_gap_%0d", i), 32'(ifb.en), 32'h0);
    end
    tick();
    chk("dead_next_en", 32'(ifb.en), 32'h4);
    chk("dead_next_id", 32'(ifb.gnt_id), 32'h2);

    // Sole requester never pre-empted
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("sole_en", 32'(ifb.en), 32'h4);
    end

    // MAX_HOLD=0: unlimited hold
    do_reset();
    ifc.req = 4'b0011;
    tick();
    chk("nohold_first", 32'(ifc.en), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nohold_keep", 32'(ifc.en), 32'h1);
    end
    ifc.req = 4'b0010;
    tick();
    chk("nohold_dead", 32'(ifc.en), 32'h0);
    tick();
    chk("nohold_next", 32'(ifc.en), 32'h2);
    chk("nohold_id",   32'(ifc.gnt_id), 32'h1);

    // Async reset mid-grant, pointer returns to N-1
    do_reset();
    ifb.req = 4'b0001;
    tick();
    chk("ar_own0", 32'(ifb.en), 32'h1);
    ifb.req = 4'b0010;
    repeat (3) tick();
    tick();
    chk("ar_own1", 32'(ifb.en), 32'h2);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_en_clear", 32'(ifb.en), 32'h0);
    chk("ar_valid",    32'(ifb.gnt_valid), 32'h0);
    chk("ar_idle",     32'(ifb.bus_idle), 32'h1);
    chk("ar_id",       32'(ifb.gnt_id), 32'h0);
    ifb.req = 4'b0110;
    #2 rst_n = 1'b1;
    #1;
    chk("ar_no_early", 32'(ifb.en), 32'h0);
    tick();
    chk("ar_regrant_en", 32'(ifb.en), 32'h2);
    chk("ar_regrant_id", 32'(ifb.gnt_id), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
